// File: rtl/datapath_seq.sv
// datapath_seq: self-sequencing register-file datapath.
//
// Holds an NREGS x WIDTH register file, the A/B/C operand registers, a one-bit shifter,
// a 2-op ALU and Z/N/V status flags. One start pulse in IDLE latches a complete operation.
// The internal FSM then runs it without further input from the controller.
//   ALU ops   (vsel==11): IDLE -> RDA -> RDB -> EXEC -> WB
//   load ops  (vsel!=11): IDLE -> WB
//
// Optional build macro:
//   CARRY_FLAG_EN - adds the C_out carry/no-borrow flag and its logic.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin an operation (sampled only in IDLE)
//   rd, rn, rm          destination / A-operand / B-operand register indices
//   shift, aluop        B-operand shift and ALU function
//   asel, bsel          force ALU A to 0 / take ALU B from imm
//   vsel, wb_en         writeback source select and write enable
//   loads               update flags in EXEC
//   imm, mdata, pc      immediate, memory read data, program counter
//   busy, done          busy in every non-IDLE state; done pulses in WB
//   result              last ALU result (C)
//   Z_out, N_out, V_out status flags (plus C_out when CARRY_FLAG_EN is defined)
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_W  = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic [1:0]       shift,
  input  logic [1:0]       aluop,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       vsel,
  input  logic             wb_en,
  input  logic             loads,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef CARRY_FLAG_EN
  output logic             C_out,
`endif
  output logic             Z_out,
  output logic             N_out,
  output logic             V_out
);

  typedef enum logic [2:0] {StIdle, StRda, StRdb, StExec, StWb} state_e;

  // Register count widened by one bit so out-of-range indices can be detected.
  localparam logic [RW:0] NregsL = (RW + 1)'(NREGS);

  state_e state_q, state_d;

  // Latched operation fields, stable for the whole operation.
  logic [RW-1:0]    op_rd_q, op_rn_q, op_rm_q;
  logic [1:0]       op_shift_q, op_aluop_q, op_vsel_q;
  logic             op_asel_q, op_bsel_q, op_wb_en_q, op_loads_q;
  logic [WIDTH-1:0] op_imm_q, op_mdata_q;
  logic [PC_W-1:0]  op_pc_q;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             z_q, n_q, v_q;

  logic             accept;
  logic             rd_ok, rn_ok, rm_ok;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] ain, bsh, bin, alu_out;
  logic             alu_v;
  logic [WIDTH-1:0] wb_val;

  assign accept = (state_q == StIdle) && start;

  // Indices at or beyond NREGS read as zero and never write.
  assign rd_ok = ({1'b0, op_rd_q} < NregsL);
  assign rn_ok = ({1'b0, op_rn_q} < NregsL);
  assign rm_ok = ({1'b0, op_rm_q} < NregsL);
  assign rd_a  = rn_ok ? regs_q[op_rn_q] : '0;
  assign rd_b  = rm_ok ? regs_q[op_rm_q] : '0;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (vsel == 2'b11) ? StRda : StWb;
        end
      end
      StRda:   state_d = StRdb;
      StRdb:   state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StWb);
  end

  // ---------------------------------------------------------------------------
  // Operation register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rd_q    <= '0;
      op_rn_q    <= '0;
      op_rm_q    <= '0;
      op_shift_q <= '0;
      op_aluop_q <= '0;
      op_asel_q  <= 1'b0;
      op_bsel_q  <= 1'b0;
      op_vsel_q  <= '0;
      op_wb_en_q <= 1'b0;
      op_loads_q <= 1'b0;
      op_imm_q   <= '0;
      op_mdata_q <= '0;
      op_pc_q    <= '0;
    end else if (accept) begin
      op_rd_q    <= rd;
      op_rn_q    <= rn;
      op_rm_q    <= rm;
      op_shift_q <= shift;
      op_aluop_q <= aluop;
      op_asel_q  <= asel;
      op_bsel_q  <= bsel;
      op_vsel_q  <= vsel;
      op_wb_en_q <= wb_en;
      op_loads_q <= loads;
      op_imm_q   <= imm;
      op_mdata_q <= mdata;
      op_pc_q    <= pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter and ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    ain = op_asel_q ? '0 : a_q;
    case (op_shift_q)
      2'b00:   bsh = b_q;
      2'b01:   bsh = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   bsh = {1'b0, b_q[WIDTH-1:1]};
      default: bsh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
    endcase
    bin     = op_bsel_q ? op_imm_q : bsh;
    alu_out = '0;
    alu_v   = 1'b0;
    case (op_aluop_q)
      2'b00: begin
        alu_out = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b01: begin
        alu_out = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

`ifdef CARRY_FLAG_EN
  logic [WIDTH:0] sum_ext;
  logic           alu_c;
  logic           c_flag_q;

  // Subtraction reports "no borrow", i.e. Ain >= Bin unsigned.
  always_comb begin
    sum_ext = {1'b0, ain} + {1'b0, bin};
    case (op_aluop_q)
      2'b00:   alu_c = sum_ext[WIDTH];
      2'b01:   alu_c = (ain >= bin);
      default: alu_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_flag_q <= 1'b0;
    end else if ((state_q == StExec) && op_loads_q) begin
      c_flag_q <= alu_c;
    end
  end

  assign C_out = c_flag_q;
`endif

  // ---------------------------------------------------------------------------
  // Operand registers, result and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      if (state_q == StRda) a_q <= rd_a;
      if (state_q == StRdb) b_q <= rd_b;
      if (state_q == StExec) begin
        c_q <= alu_out;
        if (op_loads_q) begin
          z_q <= (alu_out == '0);
          n_q <= alu_out[WIDTH-1];
          v_q <= alu_v;
        end
      end
    end
  end

  assign result = c_q;
  assign Z_out  = z_q;
  assign N_out  = n_q;
  assign V_out  = v_q;

  // ---------------------------------------------------------------------------
  // Writeback and register file
  // ---------------------------------------------------------------------------
  always_comb begin
    case (op_vsel_q)
      2'b00:   wb_val = op_mdata_q;
      2'b01:   wb_val = op_imm_q;
      2'b10:   wb_val = WIDTH'(op_pc_q);
      default: wb_val = c_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if ((state_q == StWb) && op_wb_en_q && rd_ok) begin
      regs_q[op_rd_q] <= wb_val;
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq (default parameters, WIDTH=16, NREGS=8, PC_W=8).
// A behavioural model computes every expected result from plain integer arithmetic.
module tb_datapath_seq;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  rd, rn, rm;
  logic [1:0]  shift, aluop, vsel;
  logic        asel, bsel, wb_en, loads;
  logic [15:0] imm, mdata;
  logic [7:0]  pc;
  logic        busy, done;
  logic [15:0] result;
  logic        Z_out, N_out, V_out;
  logic        c_flag;

  always #5 clk = ~clk;

  datapath_seq #(
    .WIDTH(W),
    .NREGS(8),
    .PC_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rd    (rd),
    .rn    (rn),
    .rm    (rm),
    .shift (shift),
    .aluop (aluop),
    .asel  (asel),
    .bsel  (bsel),
    .vsel  (vsel),
    .wb_en (wb_en),
    .loads (loads),
    .imm   (imm),
    .mdata (mdata),
    .pc    (pc),
    .busy  (busy),
    .done  (done),
    .result(result),
`ifdef CARRY_FLAG_EN
    .C_out (c_flag),
`endif
    .Z_out (Z_out),
    .N_out (N_out),
    .V_out (V_out)
  );

`ifndef CARRY_FLAG_EN
  assign c_flag = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0] m_regs [8];
  logic [15:0] m_result;
  logic [3:0]  m_flags;  // {Z, N, V, C}
  int          exp_cycles;

  // Observations from the last run_op
  int          obs_cycles;
  int          done_pulses;
  bit          busy_gap;
  logic        busy_after;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_result = 16'h0;
    m_flags  = 4'h0;
  endtask

  task automatic idle_inputs();
    start = 1'b0; rd = '0; rn = '0; rm = '0; shift = '0; aluop = '0; vsel = '0;
    asel = 1'b0; bsel = 1'b0; wb_en = 1'b0; loads = 1'b0; imm = '0; mdata = '0; pc = '0;
  endtask

  // Issue one operation at a negedge in IDLE, update the model, wait for done.
  // Returns at the negedge of the cycle after done (FSM back in IDLE).
  task automatic run_op(input logic [2:0] rd_v, input logic [2:0] rn_v, input logic [2:0] rm_v,
                        input logic [1:0] sh_v, input logic [1:0] op_v, input logic as_v,
                        input logic bs_v, input logic [1:0] vs_v, input logic wb_v,
                        input logic ld_v, input logic [15:0] imm_v, input logic [15:0] md_v,
                        input logic [7:0] pc_v, input bit hammer);
    int unsigned ai, bi, braw, bs, o, full;
    int          sa, sb, s;
    bit          mz, mn, mv, mc;
    logic [15:0] src;
    // Model: integer arithmetic straight from the operation definition.
    ai   = as_v ? 0 : int'(m_regs[rn_v]);
    braw = m_regs[rm_v];
    case (sh_v)
      2'd0:    bs = braw;
      2'd1:    bs = (braw * 2) % 65536;
      2'd2:    bs = braw / 2;
      default: bs = braw / 2 + ((braw >= 32768) ? 32768 : 0);
    endcase
    bi = bs_v ? int'(imm_v) : bs;
    sa = (ai >= 32768) ? int'(ai) - 65536 : int'(ai);
    sb = (bi >= 32768) ? int'(bi) - 65536 : int'(bi);
    mv = 1'b0;
    mc = 1'b0;
    case (op_v)
      2'd0: begin
        full = ai + bi; o = full % 65536; s = sa + sb;
        mv = (s > 32767) || (s < -32768); mc = (full >= 65536);
      end
      2'd1: begin
        o = (ai + 65536 - bi) % 65536; s = sa - sb;
        mv = (s > 32767) || (s < -32768); mc = (ai >= bi);
      end
      2'd2:    o = ai & bi;
      default: o = 65535 - bi;
    endcase
`ifndef CARRY_FLAG_EN
    mc = 1'b0;
`endif
    mz = (o == 0);
    mn = (o >= 32768);
    if (vs_v == 2'b11) begin
      m_result = o[15:0];
      if (ld_v) m_flags = {mz, mn, mv, mc};
    end
    case (vs_v)
      2'd0:    src = md_v;
      2'd1:    src = imm_v;
      2'd2:    src = {8'h00, pc_v};
      default: src = m_result;
    endcase
    exp_cycles = (vs_v == 2'b11) ? 4 : 1;

    rd = rd_v; rn = rn_v; rm = rm_v; shift = sh_v; aluop = op_v; asel = as_v; bsel = bs_v;
    vsel = vs_v; wb_en = wb_v; loads = ld_v; imm = imm_v; mdata = md_v; pc = pc_v;
    start = 1'b1;
    obs_cycles  = -1;
    done_pulses = 0;
    busy_gap    = 1'b0;
    for (int i = 1; i <= 12 && obs_cycles < 0; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_gap = 1'b1;
      if (done === 1'b1) begin
        done_pulses++;
        obs_cycles = i;
        start = 1'b0;
      end else if (hammer) begin
        // Keep start high and scramble every field; none of it may be taken.
        rd = 3'($urandom); rn = 3'($urandom); rm = 3'($urandom); shift = 2'($urandom);
        aluop = 2'($urandom); vsel = 2'($urandom); asel = 1'($urandom);
        bsel = 1'($urandom); wb_en = 1'($urandom); loads = 1'($urandom);
        imm = 16'($urandom); mdata = 16'($urandom); pc = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy;
    if (done === 1'b1) done_pulses++;
    if (wb_v) m_regs[rd_v] = src;
  endtask

  // ALU op that copies R[idx] into result without touching flags or registers.
  task automatic read_reg(input logic [2:0] idx);
    run_op(3'd0, 3'd0, idx, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0, 0);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++;
    if (result !== 16'h0) begin n_bad++; $display("FAIL reset_result got %h want 0000", result); end
    n_cmp++;
    if ({Z_out, N_out, V_out, c_flag} !== 4'h0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {Z_out, N_out, V_out, c_flag});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    run_op(3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 16'h0007, 16'h1234,
           8'h55, 0);
    n_cmp++;
    if (obs_cycles != 1) begin n_bad++; $display("FAIL load_latency got %0d want 1", obs_cycles); end
    n_cmp++;
    if (done_pulses != 1 || busy_gap || busy_after !== 1'b0) begin
      n_bad++; $display("FAIL load_handshake got pulses=%0d gap=%0b busy_after=%b want 1/0/0",
                        done_pulses, busy_gap, busy_after);
    end
    n_cmp++;
    if (result !== 16'h0 || {Z_out, N_out, V_out, c_flag} !== 4'h0) begin
      n_bad++; $display("FAIL load_no_alu got result=%h flags=%b want 0000/0000", result,
                        {Z_out, N_out, V_out, c_flag});
    end
    read_reg(3'd1);
    n_cmp++;
    if (result !== 16'h0007) begin n_bad++; $display("FAIL load_r1 got %h want 0007", result); end
  endtask

  task automatic test_add();
    run_op(3'd2, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 16'h0005, 16'h0, 8'h0, 0);
    run_op(3'd3, 3'd1, 3'd2, 2'b01, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, 8'h0, 0);
    n_cmp++;
    if (obs_cycles != 4) begin n_bad++; $display("FAIL add_latency got %0d want 4", obs_cycles); end
    n_cmp++;
    if (result !== 16'h0011) begin n_bad++; $display("FAIL add_result got %h want 0011", result); end
    n_cmp++;
    if ({Z_out, N_out, V_out, c_flag} !== m_flags || m_flags !== 4'b0000) begin
      n_bad++; $display("FAIL add_flags got %b want %b", {Z_out, N_out, V_out, c_flag}, m_flags);
    end
    read_reg(3'd3);
    n_cmp++;
    if (result !== 16'h0011) begin n_bad++; $display("FAIL add_r3 got %h want 0011", result); end
  endtask

  task automatic test_overflow();
    run_op(3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 16'h7fff, 16'h0, 8'h0, 0);
    run_op(3'd0, 3'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 16'h0001, 16'h0, 8'h0, 0);
    n_cmp++;
    if (result !== 16'h8000) begin n_bad++; $display("FAIL ovf_result got %h want 8000", result); end
    n_cmp++;
    if ({Z_out, N_out, V_out} !== 3'b011 || {Z_out, N_out, V_out, c_flag} !== m_flags) begin
      n_bad++; $display("FAIL ovf_flags got %b want %b", {Z_out, N_out, V_out, c_flag}, m_flags);
    end
    run_op(3'd0, 3'd1, 3'd1, 2'b00, 2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 16'h0, 16'h0, 8'h0, 0);
    n_cmp++;
    if (result !== 16'h0000) begin n_bad++; $display("FAIL sub_result got %h want 0000", result); end
    n_cmp++;
    if ({Z_out, N_out, V_out} !== 3'b100 || {Z_out, N_out, V_out, c_flag} !== m_flags) begin
      n_bad++; $display("FAIL sub_flags got %b want %b", {Z_out, N_out, V_out, c_flag}, m_flags);
    end
  endtask

  task automatic test_shifter();
    run_op(3'd2, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 16'h8004, 16'h0, 8'h0, 0);
    run_op(3'd0, 3'd0, 3'd2, 2'b11, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 16'h0, 16'h0, 8'h0, 0);
    n_cmp++;
    if (result !== 16'h3ffd) begin n_bad++; $display("FAIL asr_not got %h want 3ffd", result); end
    run_op(3'd0, 3'd0, 3'd2, 2'b10, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 16'h0, 16'h0, 8'h0, 0);
    n_cmp++;
    if (result !== 16'hbffd) begin n_bad++; $display("FAIL lsr_not got %h want bffd", result); end
    n_cmp++;
    if ({Z_out, N_out, V_out, c_flag} !== m_flags) begin
      n_bad++; $display("FAIL lsr_flags got %b want %b", {Z_out, N_out, V_out, c_flag}, m_flags);
    end
  endtask

  task automatic test_back_to_back();
    // R4 <= R1 + R2 = 7fff + 8004, with start held high throughout.
    run_op(3'd4, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, 8'h0, 1);
    n_cmp++;
    if (obs_cycles != 4 || done_pulses != 1 || busy_after !== 1'b0) begin
      n_bad++; $display("FAIL busy_ignore got cycles=%0d pulses=%0d busy_after=%b want 4/1/0",
                        obs_cycles, done_pulses, busy_after);
    end
    n_cmp++;
    if (result !== 16'h0003) begin n_bad++; $display("FAIL busy_result got %h want 0003", result); end
    // Next op issued immediately, reading the register just written.
    run_op(3'd5, 3'd4, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, 8'h0, 0);
    n_cmp++;
    if (obs_cycles != 4 || result !== 16'h0006) begin
      n_bad++; $display("FAIL b2b_hazard got cycles=%0d result=%h want 4/0006", obs_cycles, result);
    end
    // Load from pc then mdata back to back.
    run_op(3'd6, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 16'h0, 16'h0, 8'hc3, 0);
    run_op(3'd7, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 16'h0, 16'ha55a, 8'h0, 0);
    read_reg(3'd6);
    n_cmp++;
    if (result !== 16'h00c3) begin n_bad++; $display("FAIL pc_load got %h want 00c3", result); end
    read_reg(3'd7);
    n_cmp++;
    if (result !== 16'ha55a) begin n_bad++; $display("FAIL mdata_load got %h want a55a", result); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    rd = 3'd5; rn = 3'd4; rm = 3'd4; shift = 2'b00; aluop = 2'b00; asel = 1'b0; bsel = 1'b0;
    vsel = 2'b11; wb_en = 1'b1; loads = 1'b1; imm = 16'h0; mdata = 16'h0; pc = 8'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);  // now in EXEC
    rst_n = 1'b0;
    #1;
    model_clear();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0) begin
      n_bad++; $display("FAIL midreset_outputs got busy=%b done=%b result=%h want 0/0/0000",
                        busy, done, result);
    end
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0) begin n_bad++; $display("FAIL midreset_quiet got %0d want 0", seen_done); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i));
      n_cmp++;
      if (result !== 16'h0) begin n_bad++; $display("FAIL midreset_r%0d got %h want 0000", i, result); end
    end
    run_op(3'd2, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 16'hfffe, 16'h0, 8'h0, 0);
    n_cmp++;
    if (obs_cycles != 4 || result !== 16'hfffe || {Z_out, N_out, V_out, c_flag} !== m_flags) begin
      n_bad++; $display("FAIL midreset_next got cycles=%0d result=%h flags=%b want 4/fffe/%b",
                        obs_cycles, result, {Z_out, N_out, V_out, c_flag}, m_flags);
    end
  endtask

  task automatic test_random();
    logic [1:0] vs;
    for (int k = 0; k < 150; k++) begin
      vs = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom);
      run_op(3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), vs, 1'($urandom),
             1'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0));
      n_cmp++;
      if (obs_cycles != exp_cycles || done_pulses != 1 || busy_gap || busy_after !== 1'b0) begin
        n_bad++; $display("FAIL rand%0d_seq got cycles=%0d pulses=%0d gap=%0b want %0d/1/0", k,
                          obs_cycles, done_pulses, busy_gap, exp_cycles);
      end
      n_cmp++;
      if (result !== m_result || {Z_out, N_out, V_out, c_flag} !== m_flags) begin
        n_bad++; $display("FAIL rand%0d_data got %h/%b want %h/%b", k, result,
                          {Z_out, N_out, V_out, c_flag}, m_result, m_flags);
      end
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i));
      n_cmp++;
      if (result !== m_regs[i]) begin
        n_bad++; $display("FAIL rand_r%0d got %h want %h", i, result, m_regs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_overflow();
    test_shifter();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised, self-sequencing successor of the single-cycle-controlled datapath.
- Contains its own NREGS x WIDTH register file, A/B/C operand registers, shifter, ALU and status flags.
- An internal FSM accepts one operation per start pulse and runs read-A, read-B, execute and writeback automatically, so the external controller issues only start and waits for done.
- Sits between the CPU instruction decoder/controller and memory/PC logic.

Parameters:
- WIDTH, 16: datapath and register width in bits (>= 4).
- NREGS, 8: number of registers; register index width RW = clog2(NREGS).
- PC_W, 8: PC input width; zero-extended to WIDTH (PC_W <= WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- rd  in  RW  destination register
- rn  in  RW  A-operand register
- rm  in  RW  B-operand register
- shift  in  2  B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
- aluop  in  2  00 A+B, 01 A-B, 10 A&B, 11 ~B
- asel  in  1  1: ALU A input forced to 0
- bsel  in  1  1: ALU B input = imm (unshifted)
- vsel  in  2  writeback source: 00 mdata, 01 imm, 10 {0,pc}, 11 ALU result C
- wb_en  in  1  1: write the vsel source to R[rd] in WB
- loads  in  1  1: update flags in EXEC
- imm  in  WIDTH  sign-extended immediate
- mdata  in  WIDTH  memory read data
- pc  in  PC_W  program counter
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in the WB state
- result  out  WIDTH  last C value
- Z_out, N_out, V_out  out  1  status flags

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE. All of R[0..NREGS-1], A, B, C, result and the flags are cleared to 0. busy and done are 0. Reset asserted mid-operation aborts the operation with no writeback.
- Handshake:
  - In IDLE, start=1 latches all op fields (rd..pc) into an op register; these latched values are used for the whole operation.
  - start is ignored while busy=1. No queueing.
- FSM states: IDLE, RDA, RDB, EXEC, WB.
  - IDLE, start with vsel==11 -> RDA.
  - IDLE, start with vsel!=11 -> WB. The ALU is bypassed; flags and C are unchanged.
  - RDA: A <= R[rn] -> RDB.
  - RDB: B <= R[rm] -> EXEC.
  - EXEC:
    - Ain = asel ? 0 : A.
    - Bin = bsel ? imm : shift(B).
    - C and result <= ALU(Ain, Bin).
    - If loads=1, flags update from the same ALU evaluation.
    - Next state -> WB.
  - WB: if wb_en=1, R[rd] <= selected source; done=1 -> IDLE.
- Latency:
  - vsel==11: start sampled at edge 0; done high in the cycle after edge 3; R[rd] updated at edge 4.
  - vsel!=11: done high in the cycle after edge 0; R[rd] updated at edge 1.
  - A new start may be presented in the cycle after done (back-to-back throughput: 5 cycles for ALU ops, 2 for loads).
- Arithmetic rules:
  - All results are modulo 2^WIDTH.
  - ASR replicates the MSB; LSR and LSL shift in 0.
  - Z = (out==0); N = out[WIDTH-1].
  - V for add: Ain and Bin signs equal and out sign differs.
  - V for sub: Ain and Bin signs differ and out sign differs from Ain.
  - V = 0 for AND and NOT.
- Hazards: register reads happen in RDA/RDB, after any prior WB. A following op always sees a prior write; no bypass is needed.
- rn==rm and rd==rn are legal.
- Indices >= NREGS (non-power-of-2 NREGS) read 0 and are not written.

Optional Feature:
- Macro CARRY_FLAG_EN.
- When defined:
  - Adds output port C_out (1 bit, reset 0).
  - C_out updates with the other flags when loads=1: carry out of A+B, or no-borrow (Ain >= Bin unsigned) for A-B.
  - C_out = 0 for AND and NOT.
- When undefined: no C_out port and no carry logic; all other behaviour is identical.

Test Plan:
- Reset, then a load op vsel=01, imm=0x0007, rd=1, wb_en=1 -> busy for one cycle, done pulses, R1=0x0007. Flags and result stay 0.
- R1=7, R2=5; ALU add rn=1, rm=2, shift=01, vsel=11, rd=3, loads=1 -> done 4 cycles after start, R3=0x0011, result=0x0011, Z=0, N=0, V=0.
- Overflow: R1=0x7FFF, bsel=1, imm=0x0001, add, loads=1 -> result=0x8000, N=1, V=1, Z=0. Then sub with R1 rn and R1 rm -> result 0, Z=1, V=0 (with CARRY_FLAG_EN: C_out=1).
- Shifter: R2=0x8004 with shift=11 and aluop=11 -> result ~0xC002 = 0x3FFD. Same with shift=10 -> ~0x4002 = 0xBFFD.
- Busy rule: start re-asserted every cycle during an ALU op -> ignored until done. The next op starts the cycle after done, and back-to-back ops reading the prior rd see the new value.
- Reset mid-op: assert rst_n=0 in EXEC -> busy=0, done never pulses, all registers read 0 afterwards, and the next start executes normally.
